// File: rtl/cache_wb.sv
// rtl/cache_wb.sv - set-associative write-back cache with per-set LRU and a one-word-at-a-time memory port
module cache_wb #(
    parameter int WORD_SELECT_BIT = 3,
    parameter int INDEX_BIT       = 2,
    parameter int NASSOC          = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  rw_flag,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    input  logic        flush_flag,
    input  logic [31:0] flush_addr,
    output logic [1:0]  mem_rw_flag,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy,
    input  logic        mem_done
);
    localparam int NWORD = 1 << WORD_SELECT_BIT;
    localparam int NSET  = 1 << INDEX_BIT;
    localparam int TAG_W = 30 - WORD_SELECT_BIT - INDEX_BIT;
    localparam int WAY_W = (NASSOC > 1) ? $clog2(NASSOC) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state, state_nxt;

    logic [31:0]       data_mem  [NSET][NASSOC][NWORD];
    logic [TAG_W-1:0]  tag_mem   [NSET][NASSOC];
    logic [NASSOC-1:0] valid_mem [NSET];
    logic [NASSOC-1:0] dirty_mem [NSET];
    logic [WAY_W-1:0]  age_mem   [NSET][NASSOC];

    logic                       req_flush, req_hit;
    logic [1:0]                 req_rw;
    logic [TAG_W-1:0]           req_tag;
    logic [INDEX_BIT-1:0]       req_idx;
    logic [WORD_SELECT_BIT-1:0] req_word;
    logic [31:0]                req_wdata;
    logic [3:0]                 req_wmask;
    logic [WAY_W-1:0]           req_way;
    logic                       pend;
    logic [WORD_SELECT_BIT-1:0] cnt;

    logic [31:0]                lk_addr;
    logic [TAG_W-1:0]           lk_tag;
    logic [INDEX_BIT-1:0]       lk_idx;
    logic [WORD_SELECT_BIT-1:0] lk_word;
    logic                       hit, has_inv;
    logic [WAY_W-1:0]           hit_way, inv_way, lru_way, victim, best_age;
    logic                       accept, xfer, issue, word_done, last_word, refill_start;
    logic [WORD_SELECT_BIT-1:0] xfer_word;
    logic [INDEX_BIT-1:0]       mt_idx;
    logic [WAY_W-1:0]           mt_way;
    logic [TAG_W-1:0]           mt_tag;
    logic [31:0]                wr_merged;
    logic                       unused_lk;

    assign lk_addr   = flush_flag ? flush_addr : addr;
    assign lk_tag    = lk_addr[31 -: TAG_W];
    assign lk_idx    = lk_addr[WORD_SELECT_BIT + 2 +: INDEX_BIT];
    assign lk_word   = lk_addr[2 +: WORD_SELECT_BIT];
    assign unused_lk = ^lk_addr[1:0];

    // Victim: lowest invalid way first, otherwise the oldest way (lowest index on ties)
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        has_inv  = 1'b0;
        inv_way  = '0;
        lru_way  = '0;
        best_age = '0;
        for (int i = 0; i < NASSOC; i++) begin
            if (valid_mem[lk_idx][i] && tag_mem[lk_idx][i] == lk_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
            if (!has_inv && !valid_mem[lk_idx][i]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(i);
            end
            if (age_mem[lk_idx][i] > best_age) begin
                best_age = age_mem[lk_idx][i];
                lru_way  = WAY_W'(i);
            end
        end
        victim = has_inv ? inv_way : lru_way;
    end

    assign accept       = (state == IDLE) && (flush_flag || rw_flag != 2'b00);
    assign xfer         = (state == WRITEBACK) || (state == REFILL);
    assign issue        = xfer && !pend && !mem_busy;
    assign word_done    = xfer && pend && mem_done;
    assign last_word    = word_done && (&cnt);
    assign xfer_word    = (state == WRITEBACK) ? cnt : req_word + cnt;
    assign refill_start = (state != REFILL) && (state_nxt == REFILL);

    // A refill may start straight from IDLE, before the request registers are loaded
    assign mt_idx = (state == IDLE) ? lk_idx : req_idx;
    assign mt_way = (state == IDLE) ? victim : req_way;
    assign mt_tag = (state == IDLE) ? lk_tag : req_tag;

    always_comb begin
        wr_merged = data_mem[req_idx][req_way][req_word];
        for (int b = 0; b < 4; b++)
            if (req_wmask[b]) wr_merged[8*b +: 8] = req_wdata[8*b +: 8];
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (flush_flag)
                    state_nxt = (hit && dirty_mem[lk_idx][hit_way]) ? WRITEBACK : RESPOND;
                else if (rw_flag != 2'b00)
                    state_nxt = hit ? RESPOND :
                                (valid_mem[lk_idx][victim] && dirty_mem[lk_idx][victim]) ? WRITEBACK : REFILL;
            end
            WRITEBACK: if (last_word) state_nxt = req_flush ? RESPOND : REFILL;
            REFILL:    if (last_word) state_nxt = RESPOND;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state != IDLE);
        done           = (state == RESPOND);
        read_data      = '0;
        mem_rw_flag    = 2'b00;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write_mask = 4'b0000;
        if (state == RESPOND && req_rw[0] && !req_flush)
            read_data = data_mem[req_idx][req_way][req_word];
        if (issue) begin
            if (state == WRITEBACK) begin
                mem_rw_flag    = 2'b10;
                mem_addr       = {tag_mem[req_idx][req_way], req_idx, xfer_word, 2'b00};
                mem_write_data = data_mem[req_idx][req_way][xfer_word];
                mem_write_mask = 4'b1111;
            end else begin
                mem_rw_flag = 2'b01;
                mem_addr    = {req_tag, req_idx, xfer_word, 2'b00};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == REFILL && word_done)
                data_mem[req_idx][req_way][xfer_word] <= mem_read_data;
            if (state == RESPOND && !req_flush && req_rw[1])
                data_mem[req_idx][req_way][req_word] <= wr_merged;
            if (refill_start)
                tag_mem[mt_idx][mt_way] <= mt_tag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend      <= 1'b0;
            cnt       <= '0;
            req_flush <= 1'b0;
            req_hit   <= 1'b0;
            req_rw    <= 2'b00;
            req_tag   <= '0;
            req_idx   <= '0;
            req_word  <= '0;
            req_wdata <= '0;
            req_wmask <= 4'b0000;
            req_way   <= '0;
            for (int s = 0; s < NSET; s++) begin
                valid_mem[s] <= '0;
                dirty_mem[s] <= '0;
                for (int w = 0; w < NASSOC; w++) age_mem[s][w] <= '0;
            end
        end else begin
            if (accept) begin
                req_flush <= flush_flag;
                req_rw    <= flush_flag ? 2'b00 : rw_flag;
                req_hit   <= hit;
                req_tag   <= lk_tag;
                req_idx   <= lk_idx;
                req_word  <= lk_word;
                req_wdata <= write_data;
                req_wmask <= write_mask;
                req_way   <= hit ? hit_way : victim;
            end
            if (issue) pend <= 1'b1;
            if (word_done) begin
                pend <= 1'b0;
                cnt  <= cnt + 1'b1;
            end
            if (refill_start) begin
                valid_mem[mt_idx][mt_way] <= 1'b1;
                dirty_mem[mt_idx][mt_way] <= 1'b0;
            end
            if (state == RESPOND) begin
                if (req_flush) begin
                    if (req_hit) begin
                        valid_mem[req_idx][req_way] <= 1'b0;
                        dirty_mem[req_idx][req_way] <= 1'b0;
                    end
                end else begin
                    if (req_rw[1]) dirty_mem[req_idx][req_way] <= 1'b1;
                    for (int j = 0; j < NASSOC; j++) begin
                        if (WAY_W'(j) == req_way)
                            age_mem[req_idx][j] <= '0;
                        else if (age_mem[req_idx][j] < age_mem[req_idx][req_way])
                            age_mem[req_idx][j] <= age_mem[req_idx][j] + 1'b1;
                    end
                end
            end
        end
    end
endmodule
